fb_clear_engine: RTL and testbench
==================================

# fb_clear_engine

Framebuffer clear engine: the execution unit downstream of `command_processor` that services its clear start/done handshake. On `clear_start` it latches a 32-bit clear colour and writes it to every pixel of the framebuffer, or to an inclusive rectangle when compiled with rectangle support. Writes go out through a valid/ready word-write port into framebuffer memory, one pixel per accepted beat. Completion is reported with a single-cycle `clear_done` pulse.

## Interface
- `FB_WIDTH`, 640, framebuffer width in pixels (≥1)
- `FB_HEIGHT`, 480, framebuffer height in pixels (≥1)
- `ADDR_W`, 19, pixel (word) address width; must hold `FB_WIDTH*FB_HEIGHT-1`
- `clk  in  1  single clock`
- `rst_n  in  1  reset, asynchronous assert, active-low`
- `clear_start  in  1  start pulse; sampled only in IDLE`
- `clear_color  in  32  fill value; latched with clear_start`
- `clear_done  out  1  one-cycle completion pulse`
- `busy  out  1  high in WRITE and DONE`
- `mem_wr_valid  out  1  write beat valid`
- `mem_wr_addr  out  ADDR_W  pixel address = y*FB_WIDTH + x`
- `mem_wr_data  out  32  latched clear colour`
- `mem_wr_ready  in  1  memory accepts beat`
- `rect_x0`, `rect_x1`  in  16  inclusive X bounds (only with `FB_CLEAR_RECT_EN`)
- `rect_y0`, `rect_y1`  in  16  inclusive Y bounds (only with `FB_CLEAR_RECT_EN`)

## Operation
- States: IDLE → WRITE → DONE → IDLE.
- In IDLE, `clear_start`=1 latches `clear_color`, any rectangle bounds, and the start position. The next state is WRITE, or DONE if the region is empty.
- WRITE: drive `mem_wr_valid`=1 with current addr/data. A beat completes on `valid && ready`.
- Scan order is raster: x increments first. At x = x_end, x wraps to x_start and y increments.
- The row base is tracked incrementally: add `FB_WIDTH` per row. No multiplier is used; address = row_base + x.
- After the last beat (x=x_end, y=y_end) is accepted, the state becomes DONE.
- DONE lasts one cycle: `clear_done`=1, `mem_wr_valid`=0, then IDLE.
- `clear_start` is ignored in WRITE and DONE. It is not queued.
- Reset values: state IDLE; `clear_done`, `busy`, `mem_wr_valid` = 0; `mem_wr_addr`, `mem_wr_data`, counters = 0.
- Reset mid-clear aborts immediately. No `clear_done` pulse is emitted and the partial fill is left in memory.

## Timing
- `clear_start` sampled at edge 0 → `mem_wr_valid` high in cycle 1 with the first address.
- With `mem_wr_ready` held at 1: N pixels occupy cycles 1..N, and `clear_done` is high in cycle N+1.
- Backpressure: while `valid && !ready`, addr and data hold stable and valid is never withdrawn.
- `busy` rises in cycle 1 and falls with the end of DONE. A new `clear_start` is accepted at the earliest in cycle N+2.
- Empty region: `clear_done` in cycle 1, with zero beats.

## Configuration
- `FB_CLEAR_RECT_EN` defined: rect ports exist and are latched on start.
  - x1 and y1 are clamped to `FB_WIDTH-1` and `FB_HEIGHT-1`.
  - x0>x1 or y0>y1 after clamping, or x0 ≥ `FB_WIDTH`, or y0 ≥ `FB_HEIGHT`, is an empty region.
- Not defined: rect ports are absent and the region is always the full frame, (0,0)..(`FB_WIDTH-1`,`FB_HEIGHT-1`).

## Structure
- `gfx_pkg` holds:
  - `pixel_t` (32-bit)
  - `fb_clear_state_e` (IDLE/WRITE/DONE)
  - default `FB_WIDTH`/`FB_HEIGHT` constants shared with raster and SIMD stages
- Sub-module `fb_raster_scan`: x/y counters, row-base accumulator, and last-pixel flag. It takes start/end bounds and an advance strobe. The FSM and handshake live in `fb_clear_engine`.

## Test plan
Bench parameters: `FB_WIDTH`=4, `FB_HEIGHT`=3.
- Full clear, ready=1, colour 32'hAABBCCDD → addrs 0..11 in cycles 1..12, all data AABBCCDD, `clear_done` pulse in cycle 13 only.
- Full clear, ready pattern 1,0,0,1 repeating → each address held while ready=0, 12 unique beats in order, exactly one `clear_done`.
- `clear_start` re-pulsed in cycles 3 and 13 (WRITE and DONE) with colour 32'h11111111 → ignored; all beats carry AABBCCDD, one `clear_done`.
- `rst_n`=0 asynchronously after beat 5 → `mem_wr_valid`, `busy`, `clear_done` = 0 immediately. A fresh start afterwards restarts at addr 0.
- `FB_CLEAR_RECT_EN`, rect (1,1)-(2,2) → addrs 5,6,9,10 only; `clear_done` in cycle 5.
- `FB_CLEAR_RECT_EN`, rect x0=3, x1=1 → no beats; `clear_done` in cycle 1.

Source files
------------

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared graphics types and default framebuffer geometry.
//   pixel_t          - 32-bit framebuffer word
//   fb_clear_state_e - clear engine FSM states
//   FB_WIDTH_DEF / FB_HEIGHT_DEF - default frame size shared by raster/SIMD stages
//   COORD_W          - width of pixel coordinates / rectangle bounds
package gfx_pkg;

   typedef logic [31:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } fb_clear_state_e;

   localparam int FB_WIDTH_DEF  = 640;
   localparam int FB_HEIGHT_DEF = 480;
   localparam int COORD_W       = 16;

endpackage

// File: rtl/fb_raster_scan.sv
// fb_raster_scan: raster-order pixel walker for a rectangular region.
//   clk, rst_n        - clock, async active-low reset
//   load              - capture bounds and jump to (x_start, y_start)
//   x_start..y_end    - inclusive region bounds, sampled on load
//   adv               - step to the next pixel (x first, then y)
//   addr              - current word address = row_base + x
//   last              - current pixel is (x_end, y_end)
module fb_raster_scan
   import gfx_pkg::*;
#(
   parameter int FB_WIDTH = FB_WIDTH_DEF,
   parameter int ADDR_W   = 19
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [COORD_W-1:0] x_start,
   input  logic [COORD_W-1:0] x_end,
   input  logic [COORD_W-1:0] y_start,
   input  logic [COORD_W-1:0] y_end,
   input  logic               adv,
   output logic [ADDR_W-1:0]  addr,
   output logic               last
);

   logic [COORD_W-1:0] x, y, xs, xe, ye;
   logic [ADDR_W-1:0]  row_base;

   assign addr = row_base + ADDR_W'(x);
   assign last = (x == xe) && (y == ye);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x        <= '0;
         y        <= '0;
         xs       <= '0;
         xe       <= '0;
         ye       <= '0;
         row_base <= '0;
      end else if (load) begin
         x        <= x_start;
         y        <= y_start;
         xs       <= x_start;
         xe       <= x_end;
         ye       <= y_end;
         // Only the starting row needs a product, and it is by a constant;
         // for full-frame clears y_start is 0 and this folds away.
         row_base <= ADDR_W'(y_start) * ADDR_W'(FB_WIDTH);
      end else if (adv && !last) begin
         // Holding on the last pixel keeps addr in range after the final beat.
         if (x == xe) begin
            x        <= xs;
            y        <= y + COORD_W'(1);
            row_base <= row_base + ADDR_W'(FB_WIDTH);
         end else begin
            x <= x + COORD_W'(1);
         end
      end
   end

endmodule

// File: rtl/fb_clear_engine.sv
// fb_clear_engine: fills the framebuffer (or an inclusive rectangle) with a
// latched colour through a valid/ready word-write port, one pixel per beat.
//   clk, rst_n           - clock, async active-low reset (aborts a clear)
//   clear_start          - start pulse, sampled only when idle
//   clear_color          - fill value, latched with clear_start
//   clear_done           - one-cycle completion pulse
//   busy                 - high while writing and in the done cycle
//   mem_wr_valid/ready   - write beat handshake
//   mem_wr_addr/data     - pixel address (y*FB_WIDTH + x) and colour
//   rect_x0/x1/y0/y1     - inclusive bounds, present only with FB_CLEAR_RECT_EN
// Build option: define FB_CLEAR_RECT_EN for rectangle clears; otherwise the
// whole frame is always cleared.
module fb_clear_engine
   import gfx_pkg::*;
#(
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF,
   parameter int ADDR_W    = 19
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear_start,
   input  pixel_t             clear_color,
`ifdef FB_CLEAR_RECT_EN
   input  logic [COORD_W-1:0] rect_x0,
   input  logic [COORD_W-1:0] rect_x1,
   input  logic [COORD_W-1:0] rect_y0,
   input  logic [COORD_W-1:0] rect_y1,
`endif
   output logic               clear_done,
   output logic               busy,
   output logic               mem_wr_valid,
   output logic [ADDR_W-1:0]  mem_wr_addr,
   output pixel_t             mem_wr_data,
   input  logic               mem_wr_ready
);

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(FB_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(FB_HEIGHT - 1);

   fb_clear_state_e    state, state_nxt;
   pixel_t             color_q;
   logic [COORD_W-1:0] bx0, bx1, by0, by1;
   logic               rgn_empty;
   logic               load, adv, last;

`ifdef FB_CLEAR_RECT_EN
   // Clamp the far corner to the frame; a start corner outside the frame
   // or an inverted span yields nothing to write.
   always_comb begin
      bx0 = rect_x0;
      by0 = rect_y0;
      bx1 = (rect_x1 > X_MAX) ? X_MAX : rect_x1;
      by1 = (rect_y1 > Y_MAX) ? Y_MAX : rect_y1;
      rgn_empty = (rect_x0 > X_MAX) || (rect_y0 > Y_MAX) ||
                  (bx0 > bx1) || (by0 > by1);
   end
`else
   assign bx0       = '0;
   assign by0       = '0;
   assign bx1       = X_MAX;
   assign by1       = Y_MAX;
   assign rgn_empty = 1'b0;
`endif

   assign load = (state == ST_IDLE) && clear_start;
   assign adv  = (state == ST_WRITE) && mem_wr_ready;

   fb_raster_scan #(
      .FB_WIDTH (FB_WIDTH),
      .ADDR_W   (ADDR_W)
   ) u_scan (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .x_start (bx0),
      .x_end   (bx1),
      .y_start (by0),
      .y_end   (by1),
      .adv     (adv),
      .addr    (mem_wr_addr),
      .last    (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         color_q <= '0;
      end else begin
         state <= state_nxt;
         if (load) color_q <= clear_color;
      end
   end

   assign mem_wr_data = color_q;

   always_comb begin
      state_nxt    = state;
      mem_wr_valid = 1'b0;
      clear_done   = 1'b0;
      busy         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clear_start) state_nxt = rgn_empty ? ST_DONE : ST_WRITE;
         end
         ST_WRITE: begin
            busy         = 1'b1;
            mem_wr_valid = 1'b1;
            if (mem_wr_ready && last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy       = 1'b1;
            clear_done = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fb_clear_engine.sv
// tb_fb_clear_engine: scoreboard bench for fb_clear_engine on a 4x3 frame.
// Rectangle scenarios are compiled in when FB_CLEAR_RECT_EN is defined.
module tb_fb_clear_engine;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int AW = 19;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear_start = 1'b0;
   logic [31:0]   clear_color = '0;
   logic          mem_wr_ready = 1'b0;
   logic          clear_done, busy, mem_wr_valid;
   logic [AW-1:0] mem_wr_addr;
   logic [31:0]   mem_wr_data;
`ifdef FB_CLEAR_RECT_EN
   logic [15:0]   rect_x0 = '0, rect_x1 = '0, rect_y0 = '0, rect_y1 = '0;
`endif

   always #5 clk = ~clk;

   fb_clear_engine #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_start  (clear_start),
      .clear_color  (clear_color),
`ifdef FB_CLEAR_RECT_EN
      .rect_x0      (rect_x0),
      .rect_x1      (rect_x1),
      .rect_y0      (rect_y0),
      .rect_y1      (rect_y1),
`endif
      .clear_done   (clear_done),
      .busy         (busy),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_ready (mem_wr_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // scoreboard: expected beats (cycle -1 = any cycle)
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_data[$];
   int            exp_cyc[$];
   // observations from the last run
   logic [AW-1:0] obs_addr[$];
   logic [31:0]   obs_data[$];
   int            obs_cyc[$];
   int            done_cyc[$];
   int            stall_err;
   logic          busy_a [0:127];

   function automatic void push_rect(int x0, int x1, int y0, int y1,
                                     logic [31:0] c, int c0);
      int cy = c0;
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) begin
            exp_addr.push_back(AW'(y * W + x));
            exp_data.push_back(c);
            exp_cyc.push_back(cy);
            if (cy >= 0) cy++;
         end
   endfunction

   // Drive clear_start for edge 0, returning just after that edge.
   task automatic kick(input logic [31:0] c);
      @(negedge clk);
      clear_color = c;
      clear_start = 1'b1;
      @(posedge clk);
   endtask

   // Run cycles 1..ncyc: rmode 0 = ready held 1, 1 = ready 1,0,0,1 pattern.
   // Optional extra start pulses at cycles p0/p1 carry colour pcol.
   task automatic run(input int ncyc, input int rmode, input int p0,
                      input int p1, input logic [31:0] pcol);
      logic          hold = 1'b0;
      logic [AW-1:0] pa = '0;
      logic [31:0]   pd = '0;
      obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); done_cyc.delete();
      stall_err = 0;
      for (int k = 1; k <= ncyc; k++) begin
         #1;
         clear_start  = 1'b0;
         clear_color  = 32'hDEADBEEF;
         mem_wr_ready = (rmode == 0) ? 1'b1 : (((k-1) % 4 == 0) || ((k-1) % 4 == 3));
         if (k == p0 || k == p1) begin
            clear_start = 1'b1;
            clear_color = pcol;
         end
         @(negedge clk);
         busy_a[k] = busy;
         if (hold && (!mem_wr_valid || mem_wr_addr !== pa || mem_wr_data !== pd))
            stall_err++;
         hold = mem_wr_valid && !mem_wr_ready;
         pa   = mem_wr_addr;
         pd   = mem_wr_data;
         if (mem_wr_valid && mem_wr_ready) begin
            obs_addr.push_back(mem_wr_addr);
            obs_data.push_back(mem_wr_data);
            obs_cyc.push_back(k);
         end
         if (clear_done) done_cyc.push_back(k);
         @(posedge clk);
      end
      #1;
      clear_start  = 1'b0;
      mem_wr_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_tests++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", mem_wr_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", clear_done); end
      n_tests++; if (mem_wr_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", mem_wr_addr); end
      n_tests++; if (mem_wr_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", mem_wr_data); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_ready();
      logic [AW-1:0] a, ea;
      logic [31:0]   d, ed;
      int            c, ec;
      push_rect(0, W-1, 0, H-1, 32'hAABBCCDD, 1);
      kick(32'hAABBCCDD);
      run(16, 0, 0, 0, 32'h0);
      n_tests++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL full_beats got %0d want %0d", obs_addr.size(), exp_addr.size()); end
      while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
         a = obs_addr.pop_front(); d = obs_data.pop_front(); c = obs_cyc.pop_front();
         ea = exp_addr.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
         n_tests++; if (a !== ea) begin n_fail++; $display("FAIL full_addr got %0d want %0d", a, ea); end
         n_tests++; if (d !== ed) begin n_fail++; $display("FAIL full_data got %h want %h", d, ed); end
         n_tests++; if (c != ec) begin n_fail++; $display("FAIL full_cycle got %0d want %0d", c, ec); end
      end
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 13) begin n_fail++; $display("FAIL full_done count %0d first %0d want 1 at 13", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1); end
      n_tests++; if (busy_a[1] !== 1'b1) begin n_fail++; $display("FAIL full_busy_c1 got %b want 1", busy_a[1]); end
      n_tests++; if (busy_a[13] !== 1'b1) begin n_fail++; $display("FAIL full_busy_c13 got %b want 1", busy_a[13]); end
      n_tests++; if (busy_a[14] !== 1'b0) begin n_fail++; $display("FAIL full_busy_c14 got %b want 0", busy_a[14]); end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] a, ea;
      logic [31:0]   d, ed;
      push_rect(0, W-1, 0, H-1, 32'h5A5A0F0F, -1);
      kick(32'h5A5A0F0F);
      run(32, 1, 0, 0, 32'h0);
      n_tests++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL bp_beats got %0d want %0d", obs_addr.size(), exp_addr.size()); end
      while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
         a = obs_addr.pop_front(); d = obs_data.pop_front(); void'(obs_cyc.pop_front());
         ea = exp_addr.pop_front(); ed = exp_data.pop_front(); void'(exp_cyc.pop_front());
         n_tests++; if (a !== ea) begin n_fail++; $display("FAIL bp_addr got %0d want %0d", a, ea); end
         n_tests++; if (d !== ed) begin n_fail++; $display("FAIL bp_data got %h want %h", d, ed); end
      end
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
      n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_hold_stable got %0d changes want 0", stall_err); end
      // 12 beats at 2 per 4 cycles end at cycle 24
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 25) begin n_fail++; $display("FAIL bp_done count %0d first %0d want 1 at 25", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1); end
   endtask

   task automatic test_ignore_start();
      logic [AW-1:0] a, ea;
      logic [31:0]   d, ed;
      push_rect(0, W-1, 0, H-1, 32'hAABBCCDD, 1);
      kick(32'hAABBCCDD);
      run(18, 0, 3, 13, 32'h11111111);
      n_tests++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL ign_beats got %0d want %0d", obs_addr.size(), exp_addr.size()); end
      while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
         a = obs_addr.pop_front(); d = obs_data.pop_front(); void'(obs_cyc.pop_front());
         ea = exp_addr.pop_front(); ed = exp_data.pop_front(); void'(exp_cyc.pop_front());
         n_tests++; if (a !== ea) begin n_fail++; $display("FAIL ign_addr got %0d want %0d", a, ea); end
         n_tests++; if (d !== ed) begin n_fail++; $display("FAIL ign_data got %h want %h", d, ed); end
      end
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 13) begin n_fail++; $display("FAIL ign_done count %0d first %0d want 1 at 13", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1); end
      n_tests++; if (busy_a[15] !== 1'b0) begin n_fail++; $display("FAIL ign_busy_c15 got %b want 0", busy_a[15]); end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a, ea;
      logic [31:0]   d, ed;
      int            c, ec;
      push_rect(0, W-1, 0, H-1, 32'hAABBCCDD, 1);
      push_rect(0, W-1, 0, H-1, 32'h12345678, 15);
      kick(32'hAABBCCDD);
      run(30, 0, 14, 0, 32'h12345678);
      n_tests++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL b2b_beats got %0d want %0d", obs_addr.size(), exp_addr.size()); end
      while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
         a = obs_addr.pop_front(); d = obs_data.pop_front(); c = obs_cyc.pop_front();
         ea = exp_addr.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
         n_tests++; if (a !== ea || d !== ed || c != ec) begin n_fail++; $display("FAIL b2b_beat got %0d/%h@%0d want %0d/%h@%0d", a, d, c, ea, ed, ec); end
      end
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
      n_tests++; if (done_cyc.size() != 2 || done_cyc[0] != 13 || done_cyc[1] != 27) begin n_fail++; $display("FAIL b2b_done count %0d want 2 at 13,27", done_cyc.size()); end
   endtask

   task automatic test_reset_abort();
      logic [AW-1:0] a, ea;
      logic [31:0]   d, ed;
      int            c, ec;
      mem_wr_ready = 1'b1;
      kick(32'hCAFEF00D);
      #1 clear_start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", mem_wr_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
      n_tests++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", clear_done); end
      @(negedge clk);
      rst_n = 1'b1;
      run(3, 0, 0, 0, 32'h0);
      n_tests++; if (done_cyc.size() != 0 || obs_addr.size() != 0) begin n_fail++; $display("FAIL abort_quiet got %0d done %0d beats want 0 0", done_cyc.size(), obs_addr.size()); end
      push_rect(0, W-1, 0, H-1, 32'h0F1E2D3C, 1);
      kick(32'h0F1E2D3C);
      run(16, 0, 0, 0, 32'h0);
      n_tests++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL restart_beats got %0d want %0d", obs_addr.size(), exp_addr.size()); end
      while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
         a = obs_addr.pop_front(); d = obs_data.pop_front(); c = obs_cyc.pop_front();
         ea = exp_addr.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
         n_tests++; if (a !== ea || d !== ed || c != ec) begin n_fail++; $display("FAIL restart_beat got %0d/%h@%0d want %0d/%h@%0d", a, d, c, ea, ed, ec); end
      end
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 13) begin n_fail++; $display("FAIL restart_done count %0d want 1 at 13", done_cyc.size()); end
   endtask

`ifdef FB_CLEAR_RECT_EN
   task automatic test_rect(input int x0, input int x1, input int y0, input int y1,
                            input int ex0, input int ex1, input int ey0, input int ey1,
                            input int edone);
      logic [AW-1:0] a, ea;
      logic [31:0]   d, ed;
      int            c, ec;
      rect_x0 = 16'(x0); rect_x1 = 16'(x1); rect_y0 = 16'(y0); rect_y1 = 16'(y1);
      if (ex0 >= 0) push_rect(ex0, ex1, ey0, ey1, 32'h77665544, 1);
      kick(32'h77665544);
      run(edone + 3, 0, 0, 0, 32'h0);
      n_tests++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL rect_beats got %0d want %0d", obs_addr.size(), exp_addr.size()); end
      while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
         a = obs_addr.pop_front(); d = obs_data.pop_front(); c = obs_cyc.pop_front();
         ea = exp_addr.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
         n_tests++; if (a !== ea || d !== ed || c != ec) begin n_fail++; $display("FAIL rect_beat got %0d/%h@%0d want %0d/%h@%0d", a, d, c, ea, ed, ec); end
      end
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != edone) begin n_fail++; $display("FAIL rect_done count %0d first %0d want 1 at %0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, edone); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef FB_CLEAR_RECT_EN
      rect_x0 = 16'd0; rect_x1 = 16'(W-1); rect_y0 = 16'd0; rect_y1 = 16'(H-1);
`endif
      test_full_ready();
      test_backpressure();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
`ifdef FB_CLEAR_RECT_EN
      test_rect(1, 2, 1, 2,      1, 2, 1, 2,  5);   // addrs 5,6,9,10
      test_rect(3, 1, 0, 2,     -1, 0, 0, 0,  1);   // x0 > x1: empty
      test_rect(2, 100, 1, 100,  2, 3, 1, 2,  5);   // far corner clamped
      test_rect(4, 5, 0, 0,     -1, 0, 0, 0,  1);   // x0 outside frame
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
